// File: rtl/fifo_pkg.sv
// rtl/fifo_pkg.sv - shared widths, default flag levels and reset constants for fifo_param
package fifo_pkg;

  localparam int DEF_DATA_W = 8;
  localparam int DEF_ADDR_W = 4;

  // Flag values after aclr/sclr: the FIFO is empty.
  localparam logic RST_EMPTY        = 1'b1;
  localparam logic RST_FULL         = 1'b0;
  localparam logic RST_ALMOST_EMPTY = 1'b1;
  localparam logic RST_OVERFLOW     = 1'b0;
  localparam logic RST_UNDERFLOW    = 1'b0;

  // Almost-full defaults to three quarters of the depth (12 of 16).
  function automatic int default_af_level(input int addr_w);
    int depth;
    depth = 1 << addr_w;
    return depth - depth / 4;
  endfunction

  // Almost-empty defaults to one eighth of the depth (2 of 16).
  function automatic int default_ae_level(input int addr_w);
    int depth;
    depth = 1 << addr_w;
    return depth / 8;
  endfunction

  // An empty FIFO is only almost full if the threshold is zero.
  function automatic logic rst_almost_full(input int af_level);
    return (af_level == 0) ? 1'b1 : 1'b0;
  endfunction

endpackage

// File: rtl/fifo_dpram.sv
// rtl/fifo_dpram.sv - DEPTH x DATA_W register array, synchronous write, asynchronous read
module fifo_dpram #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 4
) (
  input  logic              clock,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);

  localparam int DEPTH = 1 << ADDR_W;

  logic [DATA_W-1:0] mem [DEPTH];

  // Storage is deliberately unreset so it can later map onto an inferred RAM.
  always_ff @(posedge clock) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/fifo_param.sv
// rtl/fifo_param.sv - parametrised show-ahead synchronous FIFO; FIFO_ERR_FLAG_EN builds sticky overflow/underflow
module fifo_param
  import fifo_pkg::*;
#(
  parameter int DATA_W   = DEF_DATA_W,
  parameter int ADDR_W   = DEF_ADDR_W,
  parameter int AF_LEVEL = default_af_level(ADDR_W),
  parameter int AE_LEVEL = default_ae_level(ADDR_W)
) (
  input  logic              clock,
  input  logic              aclr,
  input  logic              sclr,
  input  logic              wrreq,
  input  logic [DATA_W-1:0] data,
  input  logic              rdreq,
  output logic [DATA_W-1:0] q,
  output logic              full,
  output logic              empty,
  output logic              almost_full,
  output logic              almost_empty,
  output logic [ADDR_W:0]   usedw,
  output logic              overflow,
  output logic              underflow
);

  localparam int DEPTH = 1 << ADDR_W;
  localparam logic [ADDR_W:0] DEPTH_CNT = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0] AF_CNT    = (ADDR_W+1)'(AF_LEVEL);
  localparam logic [ADDR_W:0] AE_CNT    = (ADDR_W+1)'(AE_LEVEL);
  localparam logic RST_ALMOST_FULL      = rst_almost_full(AF_LEVEL);

  logic [ADDR_W-1:0] wp;
  logic [ADDR_W-1:0] rp;
  logic              wr_ok;
  logic              rd_ok;
  logic [ADDR_W:0]   usedw_next;

  // A write into a full FIFO is still taken when the same edge pops the head.
  assign wr_ok      = wrreq & (~full | rdreq);
  assign rd_ok      = rdreq & ~empty;
  assign usedw_next = usedw + (ADDR_W+1)'(wr_ok) - (ADDR_W+1)'(rd_ok);

  fifo_dpram #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_ram (
    .clock (clock),
    .we    (wr_ok & ~sclr),
    .waddr (wp),
    .wdata (data),
    .raddr (rp),
    .rdata (q)
  );

  // Pointers, occupancy and flags all move together from usedw_next.
  always_ff @(posedge clock or posedge aclr) begin
    if (aclr) begin
      wp           <= '0;
      rp           <= '0;
      usedw        <= '0;
      empty        <= RST_EMPTY;
      full         <= RST_FULL;
      almost_empty <= RST_ALMOST_EMPTY;
      almost_full  <= RST_ALMOST_FULL;
    end else if (sclr) begin
      wp           <= '0;
      rp           <= '0;
      usedw        <= '0;
      empty        <= RST_EMPTY;
      full         <= RST_FULL;
      almost_empty <= RST_ALMOST_EMPTY;
      almost_full  <= RST_ALMOST_FULL;
    end else begin
      if (wr_ok) wp <= wp + 1'b1;
      if (rd_ok) rp <= rp + 1'b1;
      usedw        <= usedw_next;
      empty        <= (usedw_next == '0);
      full         <= (usedw_next == DEPTH_CNT);
      almost_empty <= (usedw_next <= AE_CNT);
      almost_full  <= (usedw_next >= AF_CNT);
    end
  end

`ifdef FIFO_ERR_FLAG_EN
  // Sticky error flags; only a clear drops them, and a cleared cycle never sets them.
  always_ff @(posedge clock or posedge aclr) begin
    if (aclr) begin
      overflow  <= RST_OVERFLOW;
      underflow <= RST_UNDERFLOW;
    end else if (sclr) begin
      overflow  <= RST_OVERFLOW;
      underflow <= RST_UNDERFLOW;
    end else begin
      if (wrreq & full & ~rdreq) overflow  <= 1'b1;
      if (rdreq & empty)         underflow <= 1'b1;
    end
  end
`else
  assign overflow  = 1'b0;
  assign underflow = 1'b0;
`endif

endmodule

// File: tb/tb_fifo_param.sv
// tb/tb_fifo_param.sv - directed bench for fifo_param with a queue-based reference model
module tb_fifo_param;

  localparam int DEPTH = 16;
`ifdef FIFO_ERR_FLAG_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  logic       clock = 1'b0;
  logic       aclr;
  logic       sclr;
  logic       wrreq;
  logic       rdreq;
  logic [7:0] data;
  logic [7:0] q;
  logic       full;
  logic       empty;
  logic       almost_full;
  logic       almost_empty;
  logic [4:0] usedw;
  logic       overflow;
  logic       underflow;

  int n_checks = 0;
  int n_fail   = 0;
  bit chk_en   = 1'b0;

  logic [7:0] mq[$];
  bit         m_ovf;
  bit         m_unf;
  bit         m_wr;
  bit         m_rd;

  fifo_param dut (
    .clock        (clock),
    .aclr         (aclr),
    .sclr         (sclr),
    .wrreq        (wrreq),
    .data         (data),
    .rdreq        (rdreq),
    .q            (q),
    .full         (full),
    .empty        (empty),
    .almost_full  (almost_full),
    .almost_empty (almost_empty),
    .usedw        (usedw),
    .overflow     (overflow),
    .underflow    (underflow)
  );

  always #5 clock = ~clock;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a queue of words plus the error rules.
  always @(posedge clock or posedge aclr) begin
    if (aclr) begin
      mq.delete();
      m_ovf = 1'b0;
      m_unf = 1'b0;
    end else if (sclr) begin
      mq.delete();
      m_ovf = 1'b0;
      m_unf = 1'b0;
    end else begin
      m_wr = wrreq && (mq.size() < DEPTH || rdreq);
      m_rd = rdreq && (mq.size() > 0);
      if (ERR_EN && wrreq && !rdreq && mq.size() == DEPTH) m_ovf = 1'b1;
      if (ERR_EN && rdreq && mq.size() == 0) m_unf = 1'b1;
      if (m_rd) void'(mq.pop_front());
      if (m_wr) mq.push_back(data);
    end
  end

  // Compare every output against the model away from the active edge.
  always @(negedge clock) begin
    if (chk_en) begin
      check("usedw", 32'(usedw), 32'(mq.size()));
      check("empty", 32'(empty), 32'(mq.size() == 0));
      check("full", 32'(full), 32'(mq.size() == DEPTH));
      check("almost_full", 32'(almost_full), 32'(mq.size() >= 12));
      check("almost_empty", 32'(almost_empty), 32'(mq.size() <= 2));
      check("overflow", 32'(overflow), 32'(m_ovf));
      check("underflow", 32'(underflow), 32'(m_unf));
      if (mq.size() > 0) check("q", 32'(q), 32'(mq[0]));
    end
  end

  task automatic step(input bit w, input bit r, input logic [7:0] d, input bit s);
    wrreq = w;
    rdreq = r;
    data  = d;
    sclr  = s;
    @(posedge clock);
    #1;
    wrreq = 1'b0;
    rdreq = 1'b0;
    sclr  = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    aclr = 1'b1; sclr = 1'b0; wrreq = 1'b0; rdreq = 1'b0; data = 8'h00;
    repeat (2) @(posedge clock);
    #1;
    aclr = 1'b0;
    chk_en = 1'b1;
    check("rst_empty", 32'(empty), 32'h1);
    check("rst_full", 32'(full), 32'h0);
    check("rst_usedw", 32'(usedw), 32'h0);
    check("rst_ae", 32'(almost_empty), 32'h1);
    check("rst_af", 32'(almost_full), 32'h0);
    check("rst_ovf", 32'(overflow), 32'h0);
    check("rst_unf", 32'(underflow), 32'h0);

    for (int i = 0; i < 16; i++) begin
      step(1'b1, 1'b0, 8'(i), 1'b0);
      if (i == 10) check("af_before_12", 32'(almost_full), 32'h0);
      if (i == 11) check("af_after_12", 32'(almost_full), 32'h1);
    end
    check("fill_full", 32'(full), 32'h1);
    check("fill_usedw", 32'(usedw), 32'd16);

    step(1'b1, 1'b0, 8'hAA, 1'b0);
    check("w17_usedw", 32'(usedw), 32'd16);
    check("w17_ovf", 32'(overflow), 32'(ERR_EN));

    for (int i = 0; i < 16; i++) begin
      check("drain_q", 32'(q), 32'(i));
      step(1'b0, 1'b1, 8'h00, 1'b0);
    end
    check("drain_empty", 32'(empty), 32'h1);

    for (int k = 0; k < 40; k++) begin
      step(1'b1, 1'b0, 8'(8'h80 + k), 1'b0);
      check("alt_q", 32'(q), 32'(8'h80 + k));
      step(1'b0, 1'b1, 8'h00, 1'b0);
    end
    check("alt_empty", 32'(empty), 32'h1);

    step(1'b0, 1'b0, 8'h00, 1'b1);
    check("sclr_ovf", 32'(overflow), 32'h0);
    for (int i = 0; i < 16; i++) step(1'b1, 1'b0, 8'(8'h10 + i), 1'b0);
    check("simf_q_before", 32'(q), 32'h10);
    step(1'b1, 1'b1, 8'hC3, 1'b0);
    check("simf_q_after", 32'(q), 32'h11);
    check("simf_usedw", 32'(usedw), 32'd16);
    check("simf_ovf", 32'(overflow), 32'h0);
    for (int i = 0; i < 15; i++) step(1'b0, 1'b1, 8'h00, 1'b0);
    check("simf_last_q", 32'(q), 32'hC3);
    step(1'b0, 1'b1, 8'h00, 1'b0);
    check("simf_drain_empty", 32'(empty), 32'h1);

    step(1'b1, 1'b1, 8'h5A, 1'b0);
    check("sime_usedw", 32'(usedw), 32'd1);
    check("sime_q", 32'(q), 32'h5A);
    check("sime_unf", 32'(underflow), 32'(ERR_EN));

    for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 8'(8'h60 + i), 1'b0);
    check("pre_sclr_usedw", 32'(usedw), 32'd5);
    step(1'b1, 1'b0, 8'hEE, 1'b1);
    check("sclr_usedw", 32'(usedw), 32'd0);
    check("sclr_empty", 32'(empty), 32'h1);
    check("sclr_unf", 32'(underflow), 32'h0);

    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 8'(8'h20 + i), 1'b0);
    #2;
    aclr = 1'b1;
    #1;
    check("aclr_usedw", 32'(usedw), 32'd0);
    check("aclr_empty", 32'(empty), 32'h1);
    check("aclr_ae", 32'(almost_empty), 32'h1);
    #2;
    aclr = 1'b0;
    step(1'b1, 1'b0, 8'h33, 1'b0);
    check("post_aclr_usedw", 32'(usedw), 32'd1);
    check("post_aclr_q", 32'(q), 32'h33);

    repeat (2) @(posedge clock);
    #1;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/fifo_param.md
# fifo_param

Parametrised synchronous FIFO, the next generation of the 8-bit/16-entry byte FIFO used on the SoC peripheral datapaths (UART-style byte streams between the Cortex-M0 bus side and peripheral logic). It adds configurable data width and depth, an occupancy count, programmable almost-full/almost-empty flags, a synchronous clear alongside an asynchronous reset, and optional sticky overflow/underflow error flags. Read data stays show-ahead: the head word is always presented on `q` without a read request.

## Interface
Parameters:
- `DATA_W`, 8: word width in bits.
- `ADDR_W`, 4: address width; depth is DEPTH = 2^ADDR_W, with ADDR_W ≥ 1.
- `AF_LEVEL`, 12: almost-full threshold, 1..DEPTH.
- `AE_LEVEL`, 2: almost-empty threshold, 0..DEPTH-1.

Ports:
- `clock`  in  1  single clock; all state changes on the rising edge.
- `aclr`  in  1  asynchronous, active-high reset.
- `sclr`  in  1  synchronous clear, active-high.
- `wrreq`  in  1  write request.
- `data`  in  DATA_W  write data.
- `rdreq`  in  1  read request (acknowledge/pop of the head word).
- `q`  out  DATA_W  head word (show-ahead).
- `full`  out  1  usedw == DEPTH.
- `empty`  out  1  usedw == 0.
- `almost_full`  out  1  usedw ≥ AF_LEVEL.
- `almost_empty`  out  1  usedw ≤ AE_LEVEL.
- `usedw`  out  ADDR_W+1  occupancy, 0..DEPTH.
- `overflow`  out  1  sticky: a write was attempted while full and not accepted.
- `underflow`  out  1  sticky: a read was attempted while empty.

## Operation
- Pointers: `wp` and `rp` are ADDR_W bits wide and wrap naturally from DEPTH-1 to 0. Occupancy is held in a registered ADDR_W+1-bit counter, not derived from a wrap flag.
- Write acceptance: `wr_ok = wrreq & (~full | rdreq)`. On acceptance, `data` is stored at `mem[wp]` and `wp` advances.
- Read acceptance: `rd_ok = rdreq & ~empty`. On acceptance, `rp` advances.
- Full with `wrreq` and `rdreq` together: both are accepted; `usedw` stays at DEPTH.
- Empty with `wrreq` and `rdreq` together: only the write is accepted (no fall-through). `usedw` becomes 1 and `underflow` is set if enabled.
- `usedw_next = usedw + wr_ok - rd_ok`. All four flags and `usedw` are registered from `usedw_next`, so they update at the same edge as the pointers.
- `q = mem[rp]` is a combinational read. It is valid whenever `empty` = 0 and don't-care when empty. The memory is never reset.
- `aclr`, asynchronous: `wp` = `rp` = 0, `usedw` = 0, `empty` = 1, `full` = 0, `almost_empty` = 1, `almost_full` = (AF_LEVEL == 0 ? 1 : 0), `overflow` = `underflow` = 0.
- `sclr` at a clock edge has the same effect as `aclr` and takes priority over `wrreq`/`rdreq` in that cycle. A request issued together with `sclr` is discarded and raises no error flag.
- Asserting `aclr` mid-stream discards all contents immediately. The first edge after release behaves as an edge with the FIFO empty.

## Timing
- Write-to-read latency: a word written at edge N appears on `q` and clears `empty` after edge N. It can be popped at edge N+1.
- Read takes effect at the edge: `q` shows the next word after the edge where `rd_ok` is true.
- Flags have zero additional latency relative to the pointer update. There is no lookahead.
- `overflow` and `underflow` hold once set. Only `aclr` or `sclr` clears them.

## Configuration
- `FIFO_ERR_FLAG_EN` defined: the `overflow`/`underflow` sticky registers are built.
  - `overflow` is set on `wrreq & full & ~rdreq`.
  - `underflow` is set on `rdreq & empty`.
- `FIFO_ERR_FLAG_EN` undefined: both ports stay present but are tied to 0, and no registers are built. The port list is identical in both builds.

## Structure
- Shared package `fifo_pkg` holds:
  - the default widths (DATA_W = 8, ADDR_W = 4);
  - a function computing the default AF/AE levels from ADDR_W;
  - the reset value constants for the flags.
- One sub-module: `fifo_dpram`, a DEPTH×DATA_W register array with a synchronous write port and an asynchronous read port. This keeps the storage swappable for an inferred RAM later.
- Pointer, counter, flag and error logic stays in `fifo_param`.

## Test plan
- Reset: after `aclr` pulse → `empty`=1, `full`=0, `usedw`=0, `almost_empty`=1, `almost_full`=0, `overflow`=0, `underflow`=0.
- Fill, default params: write 0x00..0x0F on 16 consecutive edges →
  - `almost_full` rises after the 12th write;
  - `full`=1 and `usedw`=16 after the 16th;
  - a 17th write of 0xAA is dropped, `overflow`=1 (macro on) and `usedw` stays 16.
- Drain and wrap: with the FIFO full, read 16 times → `q` sequence is 0x00..0x0F. Then write/read 40 alternating words → order preserved across the pointer wrap, and `empty`=1 at the end.
- Simultaneous at full: `wrreq`=`rdreq`=1 with `usedw`=16 → `q` advances, the new word is stored, `usedw` stays 16 and `overflow` is unchanged.
- Simultaneous at empty: `wrreq`=`rdreq`=1 with `data`=0x5A → `usedw`=1, `q`=0x5A, `underflow`=1 (macro on) or 0 (macro off).
- Clears:
  - `sclr` with 5 words stored and `wrreq` high → `usedw`=0, `empty`=1 next edge, and the write is discarded;
  - `aclr` asserted between edges → flags reset before the next edge.
